ad9945_cfg: RTL and testbench



---
 rtl/ad9945_cfg_if.sv | 19 +
 rtl/ad9945_cfg.sv | 168 ++++++++++++++++
 tb/tb_ad9945_cfg.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad9945_cfg_if.sv
// Host-side write channel of the AD9945 configuration controller.
// The master drives a register write; the slave accepts it and flags bad addresses.
interface ad9945_cfg_if;
    logic        cfg_valid;
    logic [2:0]  cfg_addr;
    logic [11:0] cfg_data;
    logic        cfg_ready;
    logic        cfg_err;

    modport master (
        output cfg_valid, cfg_addr, cfg_data,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_data,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/ad9945_cfg.sv
// AD9945 3-wire serial-port configuration controller: boots the four control registers,
// then serialises host writes. Define AD9945_CFG_AUTOINIT_EN to enable the boot sequence.
module ad9945_cfg #(
    parameter int unsigned CLK_DIV    = 8,
    parameter logic [11:0] INIT_OPER  = 12'h000,
    parameter logic [11:0] INIT_CTRL  = 12'h000,
    parameter logic [11:0] INIT_CLAMP = 12'h080,
    parameter logic [11:0] INIT_VGA   = 12'h100
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    ad9945_cfg_if.slave      cfg,
    output logic             init_done,
    output logic             SL,
    output logic             SCK,
    output logic             SDATA
);

    // state  | meaning
    // IDLE   | waiting for a boot word or a host write
    // LOAD   | word latched, SL low, bit 0 on SDATA (first low cycle of SCK)
    // SCK_LO | SCK low half-period
    // SCK_HI | SCK high half-period, AD9945 samples on the rising edge
    // HOLD   | SL still low after the last falling edge
    // GAP    | SL high, minimum spacing before the next frame
    typedef enum logic [2:0] {IDLE, LOAD, SCK_LO, SCK_HI, HOLD, GAP} state_t;

    localparam logic [7:0] HALF = 8'(CLK_DIV - 1);

`ifdef AD9945_CFG_AUTOINIT_EN
    localparam logic [2:0] BOOT_FIRST = 3'd0;
`else
    localparam logic [2:0] BOOT_FIRST = 3'd4;
`endif

    state_t      state;
    logic [7:0]  cnt;
    logic [3:0]  bit_idx;
    logic [13:0] shreg;
    logic [2:0]  boot_idx;
    logic        ready_q;
    logic        err_q;
    logic        boot_pend;
    logic [11:0] boot_val;
    logic [14:0] boot_word;
    logic [14:0] host_word;

    // boot_idx reaching 4 means every boot register has been launched
    assign boot_pend = !boot_idx[2];
    assign host_word = {cfg.cfg_data, cfg.cfg_addr};
    assign boot_word = {boot_val, 1'b0, boot_idx[1:0]};

    always_comb begin
        boot_val = INIT_OPER;
        case (boot_idx[1:0])
            2'd0: boot_val = INIT_OPER;
            2'd1: boot_val = INIT_CTRL;
            2'd2: boot_val = INIT_CLAMP;
            2'd3: boot_val = INIT_VGA;
            default: boot_val = INIT_OPER;
        endcase
    end

    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_err   = err_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            boot_idx  <= BOOT_FIRST;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            init_done <= 1'b0;
            SL        <= 1'b1;
            SCK       <= 1'b0;
            SDATA     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (boot_pend) begin
                        state    <= LOAD;
                        shreg    <= boot_word[14:1];
                        SDATA    <= boot_word[0];
                        SL       <= 1'b0;
                        bit_idx  <= '0;
                        boot_idx <= boot_idx + 3'd1;
                        ready_q  <= 1'b0;
                    end else if (cfg.cfg_valid && ready_q) begin
                        ready_q <= 1'b0;
                        if (cfg.cfg_addr[2]) begin
                            err_q <= 1'b1;
                        end else begin
                            state   <= LOAD;
                            shreg   <= host_word[14:1];
                            SDATA   <= host_word[0];
                            SL      <= 1'b0;
                            bit_idx <= '0;
                        end
                    end else begin
                        ready_q   <= 1'b1;
                        init_done <= 1'b1;
                    end
                end
                LOAD: begin
                    // LOAD already counts as the first low cycle of bit 0
                    if (HALF == 8'd0) begin
                        state <= SCK_HI;
                        SCK   <= 1'b1;
                        cnt   <= HALF;
                    end else begin
                        state <= SCK_LO;
                        cnt   <= HALF - 8'd1;
                    end
                end
                SCK_LO: begin
                    if (cnt == 8'd0) begin
                        state <= SCK_HI;
                        SCK   <= 1'b1;
                        cnt   <= HALF;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                SCK_HI: begin
                    if (cnt == 8'd0) begin
                        SCK <= 1'b0;
                        cnt <= HALF;
                        if (bit_idx == 4'd14) begin
                            state <= HOLD;
                        end else begin
                            state   <= SCK_LO;
                            bit_idx <= bit_idx + 4'd1;
                            SDATA   <= shreg[0];
                            shreg   <= {1'b0, shreg[13:1]};
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 8'd0) begin
                        state <= GAP;
                        SL    <= 1'b1;
                        SDATA <= 1'b0;
                        cnt   <= HALF;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (cnt == 8'd0) begin
                        state     <= IDLE;
                        ready_q   <= !boot_pend;
                        init_done <= !boot_pend;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad9945_cfg.sv
// Randomised self-checking bench for ad9945_cfg: frames are decoded from SL/SCK/SDATA
// and compared against a frame/timing model derived from the register-write rules.
module tb_ad9945_cfg;

    localparam logic [11:0] I0 = 12'h3C5;
    localparam logic [11:0] I1 = 12'h0A7;
    localparam logic [11:0] I2 = 12'h080;
    localparam logic [11:0] I3 = 12'h100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst2 = 1'b1;
    logic        rst1 = 1'b1;
    logic        valid = 1'b0;
    logic [2:0]  addr = '0;
    logic [11:0] data = '0;

    ad9945_cfg_if bus2();
    ad9945_cfg_if bus1();
    assign bus2.cfg_valid = valid;
    assign bus2.cfg_addr  = addr;
    assign bus2.cfg_data  = data;
    assign bus1.cfg_valid = valid;
    assign bus1.cfg_addr  = addr;
    assign bus1.cfg_data  = data;

    logic done2, sl2, sck2, sd2;
    logic done1, sl1, sck1, sd1;

    ad9945_cfg #(.CLK_DIV(2), .INIT_OPER(I0), .INIT_CTRL(I1), .INIT_CLAMP(I2), .INIT_VGA(I3)) u_d2 (
        .sys_clk(clk), .sys_rst(rst2), .cfg(bus2),
        .init_done(done2), .SL(sl2), .SCK(sck2), .SDATA(sd2)
    );

    ad9945_cfg #(.CLK_DIV(1), .INIT_OPER(I0), .INIT_CTRL(I1), .INIT_CLAMP(I2), .INIT_VGA(I3)) u_d1 (
        .sys_clk(clk), .sys_rst(rst1), .cfg(bus1),
        .init_done(done1), .SL(sl1), .SCK(sck1), .SDATA(sd1)
    );

    int   sel = 0;
    int   dv;
    logic m_sl, m_sck, m_sd, m_rdy, m_err, m_done;

    assign dv = (sel == 0) ? 2 : 1;

    always_comb begin
        m_sl = sl2; m_sck = sck2; m_sd = sd2;
        m_rdy = bus2.cfg_ready; m_err = bus2.cfg_err; m_done = done2;
        if (sel != 0) begin
            m_sl = sl1; m_sck = sck1; m_sd = sd1;
            m_rdy = bus1.cfg_ready; m_err = bus1.cfg_err; m_done = done1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame content: address bits 0..2 first, then data bits 0..11.
    function automatic logic [14:0] model_word(input logic [2:0] a, input logic [11:0] d);
        logic [14:0] w;
        for (int k = 0; k < 15; k++) w[k] = (k < 3) ? a[k] : d[k - 3];
        return w;
    endfunction

    function automatic logic [11:0] init_val(input int k);
        case (k)
            0: return I0;
            1: return I1;
            2: return I2;
            default: return I3;
        endcase
    endfunction

    task automatic do_reset(input int which, output int t0);
        @(negedge clk);
        if (which == 0) rst2 = 1'b1; else rst1 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sl", m_sl, 1);
        check("rst_sck", m_sck, 0);
        check("rst_sdata", m_sd, 0);
        check("rst_ready", m_rdy, 0);
        check("rst_err", m_err, 0);
        check("rst_done", m_done, 0);
        if (which == 0) rst2 = 1'b0; else rst1 = 1'b0;
        t0 = cyc;
    endtask

    task automatic capture(input int t0, output logic [14:0] w, output int lo_first,
                           output int lo_last, output int nb, output int bad);
        logic psck, psl;
        int   i;
        w = '0; nb = 0; lo_first = -1; lo_last = -1; bad = 0;
        psck = m_sck; psl = m_sl;
        for (int n = 0; n < 40 * dv + 80; n++) begin
            @(negedge clk);
            i = cyc - t0;
            if (!m_sl) begin
                if (lo_first < 0) lo_first = i;
                lo_last = i;
            end
            if (m_sck && !psck) begin
                if (nb < 15) begin
                    w[nb] = m_sd;
                    if (i != 1 + dv + 2 * nb * dv) bad++;
                end
                nb++;
            end
            if ((m_sl !== psl) && (m_sck || psck)) bad++;
            if (m_sck && m_sl) bad++;
            if (m_rdy && lo_first >= 0) bad++;
            psck = m_sck; psl = m_sl;
            if (lo_first >= 0 && m_sl) break;
        end
    endtask

    task automatic check_frame(input string tag, input int t0, input logic [14:0] expw);
        logic [14:0] w;
        int lo_first, lo_last, nb, bad;
        capture(t0, w, lo_first, lo_last, nb, bad);
        check({tag, "_word"}, w, expw);
        check({tag, "_sl_first"}, lo_first, 1);
        check({tag, "_sl_last"}, lo_last, 31 * dv);
        check({tag, "_nbits"}, nb, 15);
        check({tag, "_timing"}, bad, 0);
    endtask

    task automatic wait_ready(input int t0, output int t);
        t = -1;
        for (int n = 0; n < 100 * dv + 100; n++) begin
            if (m_rdy) begin
                t = cyc - t0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic host_write(input logic [2:0] a, input logic [11:0] d, output int t0);
        for (int n = 0; n < 2000 && !m_rdy; n++) @(negedge clk);
        check("host_ready_wait", m_rdy, 1);
        valid = 1'b1; addr = a; data = d;
        t0 = cyc;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic write_and_check(input string tag, input logic [2:0] a, input logic [11:0] d);
        int t0, t;
        host_write(a, d, t0);
        if (a <= 3'd3) begin
            check_frame(tag, t0, model_word(a, d));
            wait_ready(t0, t);
            check({tag, "_ready_back"}, t, 1 + 32 * dv);
        end else begin
            @(negedge clk);
            check({tag, "_err_c1"}, m_err, 1);
            check({tag, "_ready_c1"}, m_rdy, 0);
            check({tag, "_sl_c1"}, m_sl, 1);
            @(negedge clk);
            check({tag, "_err_c2"}, m_err, 0);
            check({tag, "_ready_c2"}, m_rdy, 1);
            check({tag, "_sl_c2"}, m_sl, 1);
        end
    endtask

    task automatic boot_or_direct(input string tag, input int t0);
`ifdef AD9945_CFG_AUTOINIT_EN
        int n;
        for (int k = 0; k < 4; k++)
            check_frame($sformatf("%s_boot%0d", tag, k), t0 + k * (1 + 32 * dv),
                        model_word(3'(k), init_val(k)));
        check({tag, "_done_before"}, m_done, 0);
        for (n = 0; n < 200 && !m_done; n++) @(negedge clk);
        check({tag, "_done_cycle"}, cyc - t0, 4 * (1 + 32 * dv));
        check({tag, "_ready_at_done"}, m_rdy, 1);
`else
        @(negedge clk);
        check({tag, "_done_c1"}, m_done, 1);
        check({tag, "_ready_c1"}, m_rdy, 1);
        check({tag, "_sl_idle"}, m_sl, 1);
        check({tag, "_cycle"}, cyc - t0, 1);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t;
        logic [2:0]  a, a2;
        logic [11:0] d, d2;

        sel = 0;
        do_reset(0, t0);
        boot_or_direct("d2", t0);

        write_and_check("wr_a5c", 3'd3, 12'hA5C);
        write_and_check("wr_err5", 3'd5, 12'h3F0);

        for (int i = 0; i < 8; i++) begin
            a = 3'($urandom_range(0, 7));
            d = 12'($urandom);
            write_and_check($sformatf("rnd%0d", i), a, d);
        end

        // back-to-back: valid held high across two frames
        a  = 3'($urandom_range(0, 3)); d  = 12'($urandom);
        a2 = 3'($urandom_range(0, 3)); d2 = 12'($urandom);
        for (int n = 0; n < 2000 && !m_rdy; n++) @(negedge clk);
        check("b2b_ready0", m_rdy, 1);
        valid = 1'b1; addr = a; data = d;
        t0 = cyc;
        @(posedge clk);
        #1 addr = a2; data = d2;
        check_frame("b2b0", t0, model_word(a, d));
        t1 = t0 + 1 + 32 * dv;
        for (int n = 0; n < 100 && cyc < t1; n++) @(negedge clk);
        check("b2b_ready1", m_rdy, 1);
        @(posedge clk);
        #1 valid = 1'b0;
        check_frame("b2b1", t1, model_word(a2, d2));
        wait_ready(t1, t);
        check("b2b_ready_back", t, 1 + 32 * dv);

        // reset in the middle of a frame, at the rising edge of bit 7
        host_write(3'd2, 12'($urandom), t0);
        for (int n = 0; n < 200 && cyc < t0 + 1 + dv + 14 * dv; n++) @(negedge clk);
        check("midrst_sck_high", m_sck, 1);
        check("midrst_sl_low", m_sl, 0);
        rst2 = 1'b1;
        @(negedge clk);
        check("midrst_sl", m_sl, 1);
        check("midrst_sck", m_sck, 0);
        check("midrst_done", m_done, 0);
        rst2 = 1'b0;
        t0 = cyc;
`ifdef AD9945_CFG_AUTOINIT_EN
        check_frame("reboot0", t0, model_word(3'd0, I0));
`else
        @(negedge clk);
        check("reboot_done_c1", m_done, 1);
`endif

        // CLK_DIV = 1 instance
        sel = 1;
        valid = 1'b0;
        do_reset(1, t0);
        boot_or_direct("d1", t0);
        write_and_check("d1_wr", 3'($urandom_range(0, 3)), 12'($urandom));
        write_and_check("d1_err", 3'd7, 12'($urandom));
        write_and_check("d1_wr2", 3'd1, 12'hFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
